mmcm_reconfig_sched: RTL and testbench
======================================

# mmcm_reconfig_sched

Schedules MMCM dynamic reconfiguration from frequency-range measurements. Qualifies the `freq_mode` reported by the frequency counter over several consecutive measurements, then issues a one-cycle reconfiguration step with the target state to the MMCM DRP controller. It waits for completion and lock before asserting `data_clk_rdy`. Sits between the frequency counter and the MMCM/DRP top level, replacing the simple start controller, and runs entirely in the DRP reference clock domain.

## Interface
- `STABLE_COUNT`, 4 — consecutive identical valid measurements required before acting (1..15)
- `TIMEOUT_CYCLES`, 65535 — per-wait timeout in `drp_ref_clk` cycles (1..2^20-1; used only with the macro)
- `MAX_RETRY`, 3 — reissues allowed after a timeout before declaring an error (0..7)

Ports:
- `drp_ref_clk`  in  1  sole clock; all ports synchronous to it
- `user_reset`  in  1  synchronous, active-high reset
- `freq_mode`  in  3  measured range; 1..5 are valid, 0/6/7 are invalid
- `count_done`  in  1  one-cycle pulse; `freq_mode` is valid in the same cycle
- `mmcm_srdy`  in  1  one-cycle pulse from the DRP controller when reconfiguration is complete
- `mmcm_locked`  in  1  MMCM lock, already synchronized to `drp_ref_clk`
- `sstep`  out  1  one-cycle reconfiguration start pulse
- `state`  out  3  target MMCM state; held stable from `sstep` until the next `sstep`
- `data_clk_rdy`  out  1  data clock configured and locked
- `reconfig_busy`  out  1  high while in ISSUE, WAIT_SRDY or WAIT_LOCK
- `reconfig_err`  out  1  sticky error flag; cleared only by reset
- `cur_mode`  out  3  currently applied mode; 0 means unconfigured

## Operation
- States: IDLE, ISSUE, WAIT_SRDY, WAIT_LOCK, READY, ERROR.
- Qualifier: registers `cand` (3b) and `stab_cnt` (4b, saturating at `STABLE_COUNT`).
  - Valid `count_done` with `freq_mode` == `cand`: increment `stab_cnt`.
  - Valid `count_done` with `freq_mode` != `cand`: load `cand` with `freq_mode`, set `stab_cnt` to 1.
  - `count_done` with an invalid `freq_mode`: clear `stab_cnt` to 0; `cand` is unchanged.
  - The qualifier runs only in IDLE and READY. In every other state it is held cleared and `count_done` is ignored.
- `qualified` = (`stab_cnt` == `STABLE_COUNT`) && (`cand` != `cur_mode`).
- IDLE: `qualified` -> ISSUE.
- ISSUE (one cycle): `sstep`=1, `state`<=`cand`, wait timer cleared -> WAIT_SRDY.
- WAIT_SRDY: `mmcm_srdy` -> WAIT_LOCK with timer cleared.
- WAIT_LOCK: `mmcm_locked` high -> READY; `cur_mode`<=`state`; retry counter cleared.
- READY: `data_clk_rdy`=1.
  - `mmcm_locked` low -> WAIT_LOCK; `data_clk_rdy` drops; `cur_mode` is held.
  - Otherwise `qualified` -> ISSUE; `data_clk_rdy` drops in the ISSUE cycle.
  - If both occur in the same cycle, lock loss wins.
- ERROR: terminal; `reconfig_err`=1; all outputs are held until reset.
- Reset mid-operation: FSM returns to IDLE immediately. An in-flight DRP sequence is not aborted by this block.

## Timing
- Reset values: `sstep`=0, `state`=0, `data_clk_rdy`=0, `reconfig_busy`=0, `reconfig_err`=0, `cur_mode`=0; `cand`=0, `stab_cnt`=0, retry counter=0.
- `sstep` is high in exactly the one cycle after the `count_done` that made `qualified` true (registered output). It is never high two cycles in a row.
- `mmcm_srdy` asserted in the same cycle as `sstep` is ignored.
- Latency from the `mmcm_locked` rise in WAIT_LOCK to `data_clk_rdy`=1: 1 cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `MMCM_RECFG_TIMEOUT_EN` defined:
  - A 20-bit timer runs in WAIT_SRDY and WAIT_LOCK.
  - When the timer reaches `TIMEOUT_CYCLES`, the retry counter increments. If the new count ≤ `MAX_RETRY`, go to ISSUE and reissue the same `state`; otherwise go to ERROR.
  - The timeout check takes priority over an `mmcm_srdy` or lock arriving in the same cycle.
- Macro undefined: no timer or retry logic; waits are unbounded; `reconfig_err` is tied to 0 and ERROR is unreachable.

## Test plan
- Reset, then 4 `count_done` pulses with `freq_mode`=3 -> one `sstep` pulse with `state`=3; `srdy` plus `locked` -> `data_clk_rdy`=1, `cur_mode`=3.
- Sequence 3,3,2,3,3,3,3 -> no `sstep` until the 4th consecutive 3; `freq_mode`=7 mid-run -> qualifier restarts and no `sstep` is issued.
- In READY with `cur_mode`=3, 4× `freq_mode`=5 -> `data_clk_rdy` falls and `sstep` is issued with `state`=5; 4× `freq_mode`=3 in READY -> no `sstep`.
- In READY, drop `mmcm_locked` in the same cycle that `qualified` becomes true -> WAIT_LOCK, no `sstep`; relock -> `data_clk_rdy`=1 after 1 cycle.
- With the macro, `TIMEOUT_CYCLES`=100 and `MAX_RETRY`=2, never pulse `srdy` -> `sstep` at 0, +101 and +202 cycles, then `reconfig_err`=1. Without the macro -> a single `sstep` and the block waits indefinitely.
- Assert `user_reset` during WAIT_SRDY -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/mmcm_reconfig_sched.sv
// ---------------------------------------------------------------------------
// mmcm_reconfig_sched
//
// Purpose:
//   Schedules MMCM dynamic reconfiguration from frequency-range measurements.
//   The block accepts a measured range only after it has been reported the
//   same way for several measurements in a row. It then issues a one-cycle
//   reconfiguration step with the target state to the DRP controller. It
//   waits for the DRP controller to finish and for the MMCM to lock, and
//   only then declares the data clock ready. Everything runs on drp_ref_clk.
//
// Optional feature (macro MMCM_RECFG_TIMEOUT_EN):
//   When defined, each wait for srdy/lock is bounded by a 20-bit timer. On
//   expiry the same state is reissued up to MAX_RETRY times. After that the
//   block parks in a terminal error state. When undefined, waits are
//   unbounded and reconfig_err is tied low.
//
// Parameters:
//   STABLE_COUNT   - consecutive identical valid measurements needed (1..15)
//   TIMEOUT_CYCLES - per-wait timeout in drp_ref_clk cycles (macro only)
//   MAX_RETRY      - reissues allowed after a timeout (macro only, 0..7)
//
// Ports:
//   drp_ref_clk   in   sole clock
//   user_reset    in   synchronous active-high reset
//   freq_mode     in   measured range, 1..5 valid, 0/6/7 invalid
//   count_done    in   one-cycle pulse, freq_mode valid alongside
//   mmcm_srdy     in   one-cycle DRP completion pulse
//   mmcm_locked   in   MMCM lock, already synchronized
//   sstep         out  one-cycle reconfiguration start pulse
//   state         out  target MMCM state, stable between sstep pulses
//   data_clk_rdy  out  data clock configured and locked
//   reconfig_busy out  reconfiguration in progress
//   reconfig_err  out  sticky error flag (cleared by reset only)
//   cur_mode      out  currently applied mode, 0 = unconfigured
// ---------------------------------------------------------------------------
module mmcm_reconfig_sched #(
   parameter int STABLE_COUNT   = 4,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int MAX_RETRY      = 3
) (
   input  logic       drp_ref_clk,
   input  logic       user_reset,
   input  logic [2:0] freq_mode,
   input  logic       count_done,
   input  logic       mmcm_srdy,
   input  logic       mmcm_locked,
   output logic       sstep,
   output logic [2:0] state,
   output logic       data_clk_rdy,
   output logic       reconfig_busy,
   output logic       reconfig_err,
   output logic [2:0] cur_mode
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_SRDY,
      ST_WAIT_LOCK,
      ST_READY,
      ST_ERROR
   } fsm_t;

   localparam logic [3:0] STAB_TARGET = 4'(STABLE_COUNT);

   // Catch out-of-range parameters at elaboration time.
   if (STABLE_COUNT < 1 || STABLE_COUNT > 15 ||
       TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1048575 ||
       MAX_RETRY < 0 || MAX_RETRY > 7) begin : g_param_check
      $error("mmcm_reconfig_sched: parameter out of range");
   end

   fsm_t       fsm_q, fsm_d;
   logic [2:0] cand_q, cand_d;
   logic [3:0] stab_cnt_q, stab_cnt_d;
   logic [2:0] state_q, state_d;
   logic [2:0] cur_mode_q, cur_mode_d;
   logic       sstep_q, sstep_d;
   logic       rdy_q, rdy_d;
   logic       busy_q, busy_d;
   logic       mode_valid;
   logic       qual_run;
   logic       qualified;

`ifdef MMCM_RECFG_TIMEOUT_EN
   logic [19:0] timer_q, timer_d;
   logic [2:0]  retry_q, retry_d;
   logic [3:0]  retry_inc;
   logic        err_q, err_d;
   logic        timeout;
`endif

   // Next-state logic. qualified is evaluated on the qualifier's next value,
   // so the count_done that completes a run moves the FSM to ISSUE on the
   // same edge. That edge also registers sstep, so sstep appears in the
   // cycle right after that count_done. Lock loss in READY is checked
   // before qualified, so lock loss wins when both happen in one cycle.
   always_comb begin
      fsm_d      = fsm_q;
      cand_d     = cand_q;
      stab_cnt_d = stab_cnt_q;
      state_d    = state_q;
      cur_mode_d = cur_mode_q;

      mode_valid = (freq_mode >= 3'd1) && (freq_mode <= 3'd5);
      qual_run   = (fsm_q == ST_IDLE) || (fsm_q == ST_READY);

      if (qual_run && count_done) begin
         if (!mode_valid) begin
            stab_cnt_d = 4'd0;
         end else if (freq_mode == cand_q) begin
            if (stab_cnt_q != STAB_TARGET) begin
               stab_cnt_d = stab_cnt_q + 4'd1;
            end
         end else begin
            cand_d     = freq_mode;
            stab_cnt_d = 4'd1;
         end
      end

      qualified = qual_run && (stab_cnt_d == STAB_TARGET) && (cand_d != cur_mode_q);

`ifdef MMCM_RECFG_TIMEOUT_EN
      retry_d   = retry_q;
      retry_inc = {1'b0, retry_q} + 4'd1;
      timeout   = (timer_q == 20'(TIMEOUT_CYCLES - 1));
`endif

      case (fsm_q)
         ST_IDLE: begin
            if (qualified) begin
               fsm_d   = ST_ISSUE;
               state_d = cand_d;
            end
         end
         ST_ISSUE: begin
            fsm_d = ST_WAIT_SRDY;
         end
         ST_WAIT_SRDY: begin
`ifdef MMCM_RECFG_TIMEOUT_EN
            if (timeout) begin
               retry_d = retry_inc[2:0];
               fsm_d   = (retry_inc <= 4'(MAX_RETRY)) ? ST_ISSUE : ST_ERROR;
            end else
`endif
            if (mmcm_srdy) begin
               fsm_d = ST_WAIT_LOCK;
            end
         end
         ST_WAIT_LOCK: begin
`ifdef MMCM_RECFG_TIMEOUT_EN
            if (timeout) begin
               retry_d = retry_inc[2:0];
               fsm_d   = (retry_inc <= 4'(MAX_RETRY)) ? ST_ISSUE : ST_ERROR;
            end else
`endif
            if (mmcm_locked) begin
               fsm_d      = ST_READY;
               cur_mode_d = state_q;
`ifdef MMCM_RECFG_TIMEOUT_EN
               retry_d    = 3'd0;
`endif
            end
         end
         ST_READY: begin
            if (!mmcm_locked) begin
               fsm_d = ST_WAIT_LOCK;
            end else if (qualified) begin
               fsm_d   = ST_ISSUE;
               state_d = cand_d;
            end
         end
         ST_ERROR: begin
            fsm_d = ST_ERROR;
         end
         default: begin
            fsm_d = ST_IDLE;
         end
      endcase

      // The qualifier only runs in IDLE and READY. Leaving those states
      // clears it, so a new run always starts from scratch.
      if ((fsm_d != ST_IDLE) && (fsm_d != ST_READY)) begin
         cand_d     = 3'd0;
         stab_cnt_d = 4'd0;
      end

`ifdef MMCM_RECFG_TIMEOUT_EN
      // The timer counts only while staying in the same wait state.
      // Entering any state, including a new wait state, restarts it.
      if (((fsm_d == ST_WAIT_SRDY) || (fsm_d == ST_WAIT_LOCK)) && (fsm_d == fsm_q)) begin
         timer_d = timer_q + 20'd1;
      end else begin
         timer_d = 20'd0;
      end
      err_d = (fsm_d == ST_ERROR);
`endif

      sstep_d = (fsm_d == ST_ISSUE);
      rdy_d   = (fsm_d == ST_READY);
      busy_d  = (fsm_d == ST_ISSUE) || (fsm_d == ST_WAIT_SRDY) || (fsm_d == ST_WAIT_LOCK);
   end

   // State and registered outputs. Reset returns the FSM to IDLE at once.
   // A DRP sequence already started downstream simply finishes on its own.
   always_ff @(posedge drp_ref_clk) begin
      if (user_reset) begin
         fsm_q      <= ST_IDLE;
         cand_q     <= 3'd0;
         stab_cnt_q <= 4'd0;
         state_q    <= 3'd0;
         cur_mode_q <= 3'd0;
         sstep_q    <= 1'b0;
         rdy_q      <= 1'b0;
         busy_q     <= 1'b0;
`ifdef MMCM_RECFG_TIMEOUT_EN
         timer_q    <= 20'd0;
         retry_q    <= 3'd0;
         err_q      <= 1'b0;
`endif
      end else begin
         fsm_q      <= fsm_d;
         cand_q     <= cand_d;
         stab_cnt_q <= stab_cnt_d;
         state_q    <= state_d;
         cur_mode_q <= cur_mode_d;
         sstep_q    <= sstep_d;
         rdy_q      <= rdy_d;
         busy_q     <= busy_d;
`ifdef MMCM_RECFG_TIMEOUT_EN
         timer_q    <= timer_d;
         retry_q    <= retry_d;
         err_q      <= err_d;
`endif
      end
   end

   assign sstep         = sstep_q;
   assign state         = state_q;
   assign data_clk_rdy  = rdy_q;
   assign reconfig_busy = busy_q;
   assign cur_mode      = cur_mode_q;
`ifdef MMCM_RECFG_TIMEOUT_EN
   assign reconfig_err  = err_q;
`else
   assign reconfig_err  = 1'b0;
`endif

endmodule

// File: tb/tb_mmcm_reconfig_sched.sv
// ---------------------------------------------------------------------------
// tb_mmcm_reconfig_sched
//
// Directed bench for mmcm_reconfig_sched. Inputs are driven on the falling
// edge. Outputs are sampled on the falling edge, so each sample shows the
// result of the rising edge just before it. The timeout scenario follows
// MMCM_RECFG_TIMEOUT_EN, using TIMEOUT_CYCLES=100 and MAX_RETRY=2.
// ---------------------------------------------------------------------------
module tb_mmcm_reconfig_sched;

   logic       drp_ref_clk = 1'b0;
   logic       user_reset  = 1'b1;
   logic [2:0] freq_mode   = 3'd0;
   logic       count_done  = 1'b0;
   logic       mmcm_srdy   = 1'b0;
   logic       mmcm_locked = 1'b0;
   logic       sstep;
   logic [2:0] state;
   logic       data_clk_rdy;
   logic       reconfig_busy;
   logic       reconfig_err;
   logic [2:0] cur_mode;

   int checks   = 0;
   int failures = 0;

   mmcm_reconfig_sched #(
      .STABLE_COUNT  (4),
      .TIMEOUT_CYCLES(100),
      .MAX_RETRY     (2)
   ) dut (
      .drp_ref_clk  (drp_ref_clk),
      .user_reset   (user_reset),
      .freq_mode    (freq_mode),
      .count_done   (count_done),
      .mmcm_srdy    (mmcm_srdy),
      .mmcm_locked  (mmcm_locked),
      .sstep        (sstep),
      .state        (state),
      .data_clk_rdy (data_clk_rdy),
      .reconfig_busy(reconfig_busy),
      .reconfig_err (reconfig_err),
      .cur_mode     (cur_mode)
   );

   // 100 MHz reference clock.
   always #5 drp_ref_clk = ~drp_ref_clk;

   // Advance n full cycles, landing on a falling edge.
   task automatic step(input int n);
      repeat (n) @(negedge drp_ref_clk);
   endtask

   // One count_done pulse carrying the given measurement.
   task automatic applyStimulus(input logic [2:0] mode);
      freq_mode  = mode;
      count_done = 1'b1;
      @(negedge drp_ref_clk);
      count_done = 1'b0;
   endtask

   // Synchronous reset for one edge with all inputs idle.
   task automatic doReset();
      count_done  = 1'b0;
      mmcm_srdy   = 1'b0;
      mmcm_locked = 1'b0;
      user_reset  = 1'b1;
      @(negedge drp_ref_clk);
      user_reset  = 1'b0;
   endtask

   // Drive a full reconfiguration to READY in the given mode (stimulus only).
   task automatic goToReady(input logic [2:0] mode);
      doReset();
      mmcm_locked = 1'b1;
      repeat (4) applyStimulus(mode);
      step(1);
      mmcm_srdy = 1'b1;
      step(1);
      mmcm_srdy = 1'b0;
      step(1);
   endtask

   // Every output must be zero right after reset.
   task automatic test_reset();
      doReset();
      checks++; if (sstep !== 1'b0) begin failures++; $display("[TB] FAIL reset_sstep: got %0b expected 0", sstep); end
      checks++; if (state !== 3'd0) begin failures++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
      checks++; if (data_clk_rdy !== 1'b0) begin failures++; $display("[TB] FAIL reset_rdy: got %0b expected 0", data_clk_rdy); end
      checks++; if (reconfig_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %0b expected 0", reconfig_busy); end
      checks++; if (reconfig_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %0b expected 0", reconfig_err); end
      checks++; if (cur_mode !== 3'd0) begin failures++; $display("[TB] FAIL reset_cur_mode: got %0d expected 0", cur_mode); end
   endtask

   // Four 3s give one sstep with state 3. An srdy in the sstep cycle is
   // ignored. A real srdy with lock gives ready one cycle after WAIT_LOCK.
   task automatic test_basic();
      doReset();
      mmcm_locked = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(3'd3);
         checks++; if (sstep !== 1'b0) begin failures++; $display("[TB] FAIL basic_early_sstep[%0d]: got %0b expected 0", i, sstep); end
      end
      applyStimulus(3'd3);
      checks++; if (sstep !== 1'b1) begin failures++; $display("[TB] FAIL basic_sstep: got %0b expected 1", sstep); end
      checks++; if (state !== 3'd3) begin failures++; $display("[TB] FAIL basic_state: got %0d expected 3", state); end
      checks++; if (reconfig_busy !== 1'b1) begin failures++; $display("[TB] FAIL basic_busy: got %0b expected 1", reconfig_busy); end
      mmcm_srdy = 1'b1;
      step(1);
      mmcm_srdy = 1'b0;
      checks++; if (sstep !== 1'b0) begin failures++; $display("[TB] FAIL basic_sstep_one_cycle: got %0b expected 0", sstep); end
      step(3);
      checks++; if (data_clk_rdy !== 1'b0) begin failures++; $display("[TB] FAIL basic_srdy_in_issue_ignored: rdy got %0b expected 0", data_clk_rdy); end
      checks++; if (reconfig_busy !== 1'b1) begin failures++; $display("[TB] FAIL basic_waiting_busy: got %0b expected 1", reconfig_busy); end
      mmcm_srdy = 1'b1;
      step(1);
      mmcm_srdy = 1'b0;
      checks++; if (data_clk_rdy !== 1'b0) begin failures++; $display("[TB] FAIL basic_wait_lock_rdy: got %0b expected 0", data_clk_rdy); end
      step(1);
      checks++; if (data_clk_rdy !== 1'b1) begin failures++; $display("[TB] FAIL basic_rdy: got %0b expected 1", data_clk_rdy); end
      checks++; if (cur_mode !== 3'd3) begin failures++; $display("[TB] FAIL basic_cur_mode: got %0d expected 3", cur_mode); end
      checks++; if (reconfig_busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_ready_busy: got %0b expected 0", reconfig_busy); end
   endtask

   // A different value breaks the run. An invalid value clears the count
   // but keeps the candidate.
   task automatic test_qualifier();
      logic [2:0] seq_a [7] = '{3'd3, 3'd3, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3};
      logic       exp_a [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [2:0] seq_b [7] = '{3'd3, 3'd3, 3'd3, 3'd7, 3'd3, 3'd3, 3'd3};
      doReset();
      for (int i = 0; i < 7; i++) begin
         applyStimulus(seq_a[i]);
         checks++; if (sstep !== exp_a[i]) begin failures++; $display("[TB] FAIL qual_break[%0d]: sstep got %0b expected %0b", i, sstep, exp_a[i]); end
      end
      doReset();
      for (int i = 0; i < 7; i++) begin
         applyStimulus(seq_b[i]);
         checks++; if (sstep !== 1'b0) begin failures++; $display("[TB] FAIL qual_invalid[%0d]: sstep got %0b expected 0", i, sstep); end
      end
      step(3);
      checks++; if (reconfig_busy !== 1'b0) begin failures++; $display("[TB] FAIL qual_invalid_idle: busy got %0b expected 0", reconfig_busy); end
   endtask

   // In READY, a run of the current mode does nothing. A run of a new
   // mode reissues and drops ready in the ISSUE cycle.
   task automatic test_mode_change();
      goToReady(3'd3);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(3'd3);
         checks++; if (sstep !== 1'b0) begin failures++; $display("[TB] FAIL same_mode_sstep[%0d]: got %0b expected 0", i, sstep); end
      end
      checks++; if (data_clk_rdy !== 1'b1) begin failures++; $display("[TB] FAIL same_mode_rdy: got %0b expected 1", data_clk_rdy); end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(3'd5);
         checks++; if (data_clk_rdy !== 1'b1) begin failures++; $display("[TB] FAIL new_mode_rdy_held[%0d]: got %0b expected 1", i, data_clk_rdy); end
      end
      applyStimulus(3'd5);
      checks++; if (sstep !== 1'b1) begin failures++; $display("[TB] FAIL new_mode_sstep: got %0b expected 1", sstep); end
      checks++; if (state !== 3'd5) begin failures++; $display("[TB] FAIL new_mode_state: got %0d expected 5", state); end
      checks++; if (data_clk_rdy !== 1'b0) begin failures++; $display("[TB] FAIL new_mode_rdy_drop: got %0b expected 0", data_clk_rdy); end
      checks++; if (cur_mode !== 3'd3) begin failures++; $display("[TB] FAIL new_mode_cur_held: got %0d expected 3", cur_mode); end
      step(1);
      mmcm_srdy = 1'b1;
      step(1);
      mmcm_srdy = 1'b0;
      step(1);
      checks++; if (cur_mode !== 3'd5) begin failures++; $display("[TB] FAIL new_mode_cur: got %0d expected 5", cur_mode); end
      checks++; if (data_clk_rdy !== 1'b1) begin failures++; $display("[TB] FAIL new_mode_rdy: got %0b expected 1", data_clk_rdy); end
   endtask

   // Lock loss in the same cycle as qualification wins, and no sstep is
   // issued. Relocking gives ready after one cycle.
   task automatic test_lock_loss();
      goToReady(3'd3);
      repeat (3) applyStimulus(3'd5);
      mmcm_locked = 1'b0;
      applyStimulus(3'd5);
      checks++; if (sstep !== 1'b0) begin failures++; $display("[TB] FAIL lockloss_sstep: got %0b expected 0", sstep); end
      checks++; if (data_clk_rdy !== 1'b0) begin failures++; $display("[TB] FAIL lockloss_rdy: got %0b expected 0", data_clk_rdy); end
      checks++; if (reconfig_busy !== 1'b1) begin failures++; $display("[TB] FAIL lockloss_busy: got %0b expected 1", reconfig_busy); end
      checks++; if (cur_mode !== 3'd3) begin failures++; $display("[TB] FAIL lockloss_cur: got %0d expected 3", cur_mode); end
      step(2);
      checks++; if (data_clk_rdy !== 1'b0) begin failures++; $display("[TB] FAIL lockloss_wait_rdy: got %0b expected 0", data_clk_rdy); end
      mmcm_locked = 1'b1;
      step(1);
      checks++; if (data_clk_rdy !== 1'b1) begin failures++; $display("[TB] FAIL relock_rdy: got %0b expected 1", data_clk_rdy); end
      checks++; if (sstep !== 1'b0) begin failures++; $display("[TB] FAIL relock_sstep: got %0b expected 0", sstep); end
   endtask

   // Reset in WAIT_SRDY clears every output on the next edge.
   task automatic test_reset_midop();
      doReset();
      repeat (4) applyStimulus(3'd2);
      step(1);
      checks++; if (reconfig_busy !== 1'b1) begin failures++; $display("[TB] FAIL midop_busy_before: got %0b expected 1", reconfig_busy); end
      user_reset = 1'b1;
      step(1);
      user_reset = 1'b0;
      checks++;
      if ({sstep, state, data_clk_rdy, reconfig_busy, reconfig_err, cur_mode} !== 10'd0) begin
         failures++;
         $display("[TB] FAIL midop_reset: sstep=%0b state=%0d rdy=%0b busy=%0b err=%0b cur=%0d expected all 0",
                  sstep, state, data_clk_rdy, reconfig_busy, reconfig_err, cur_mode);
      end
   endtask

   // srdy never arrives. With the timeout macro, the block reissues at +101
   // and +202, then flags an error. Without it, the block waits forever.
   task automatic test_timeout();
      int n_sstep   = 0;
      int first_at  = -1;
      int second_at = -1;
      doReset();
      mmcm_locked = 1'b1;
      repeat (4) applyStimulus(3'd4);
      checks++; if (sstep !== 1'b1) begin failures++; $display("[TB] FAIL timeout_first_sstep: got %0b expected 1", sstep); end
      for (int i = 1; i <= 320; i++) begin
         step(1);
         if (sstep === 1'b1) begin
            n_sstep++;
            if (first_at < 0) first_at = i;
            else if (second_at < 0) second_at = i;
         end
      end
`ifdef MMCM_RECFG_TIMEOUT_EN
      checks++; if (n_sstep != 2) begin failures++; $display("[TB] FAIL timeout_reissue_count: got %0d expected 2", n_sstep); end
      checks++; if (first_at != 101) begin failures++; $display("[TB] FAIL timeout_first_retry: at %0d expected 101", first_at); end
      checks++; if (second_at != 202) begin failures++; $display("[TB] FAIL timeout_second_retry: at %0d expected 202", second_at); end
      checks++; if (reconfig_err !== 1'b1) begin failures++; $display("[TB] FAIL timeout_err: got %0b expected 1", reconfig_err); end
      checks++; if (reconfig_busy !== 1'b0) begin failures++; $display("[TB] FAIL timeout_err_busy: got %0b expected 0", reconfig_busy); end
`else
      checks++; if (n_sstep != 0) begin failures++; $display("[TB] FAIL notimeout_reissue_count: got %0d expected 0", n_sstep); end
      checks++; if (reconfig_busy !== 1'b1) begin failures++; $display("[TB] FAIL notimeout_busy: got %0b expected 1", reconfig_busy); end
      checks++; if (reconfig_err !== 1'b0) begin failures++; $display("[TB] FAIL notimeout_err: got %0b expected 0", reconfig_err); end
`endif
      checks++; if (state !== 3'd4) begin failures++; $display("[TB] FAIL timeout_state_held: got %0d expected 4", state); end
   endtask

   // Run the scenarios in order and print the summary line.
   initial begin
      test_reset();
      test_basic();
      test_qualifier();
      test_mode_change();
      test_lock_loss();
      test_reset_midop();
      test_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
